// File: rtl/seg_scan_pkg.sv
// ============================================================================
// Module      : seg_scan_pkg
// Description : Shared widths, index type and anode helper for the scan mux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_scan_pkg;

    localparam int NUM_DIG = 6;
    localparam int SEG_W   = 7;

    typedef logic [2:0] dig_idx_t;

    localparam logic [NUM_DIG-1:0] AN_OFF = 6'b111111;

    // Active-low one-hot anode pattern for the given digit slot.
    function automatic logic [NUM_DIG-1:0] onehot_low(input dig_idx_t idx);
        logic [NUM_DIG-1:0] v_one;
        v_one      = {{(NUM_DIG-1){1'b0}}, 1'b1};
        onehot_low = ~(v_one << idx);
    endfunction

endpackage

`default_nettype wire

// File: rtl/scan_tick_gen.sv
// ============================================================================
// Module      : scan_tick_gen
// Description : Free-running 0..SCAN_DIV-1 slot counter with wrap tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_tick_gen #(
    parameter  int SCAN_DIV = 50000,
    localparam int CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             tick
);

    logic [CNT_W-1:0] r_cnt;

    // The parent builds its registered outputs from cnt_nxt.
    assign cnt  = r_cnt;
    assign tick = (r_cnt == CNT_W'(SCAN_DIV - 1));

    always_comb begin
        cnt_nxt = r_cnt + CNT_W'(1);
        if (tick) begin
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= cnt_nxt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/seg_scan_mux.sv
// ============================================================================
// Module      : seg_scan_mux
// Description : Six-digit time-multiplexed 7-segment driver with dead time and
//               per-frame input snapshot. Optional alarm blink: ALARM_BLINK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEAD         = 1,
    parameter int BLINK_FRAMES = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SEG_W-1:0]   seg_in0,
    input  logic [SEG_W-1:0]   seg_in1,
    input  logic [SEG_W-1:0]   seg_in2,
    input  logic [SEG_W-1:0]   seg_in3,
    input  logic [SEG_W-1:0]   seg_in4,
    input  logic [SEG_W-1:0]   seg_in5,
    input  logic [NUM_DIG-1:0] dp_mask,
    input  logic               blank,
    input  logic               alarm,
    output logic [SEG_W-1:0]   seg_out,
    output logic               dp_out,
    output logic [NUM_DIG-1:0] an_out,
    output logic [2:0]         digit_idx,
    output logic               frame_done
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0]   w_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_tick;
    dig_idx_t           r_idx;
    dig_idx_t           w_idx_nxt;
    logic               r_load_pend;
    logic               w_wrap;
    logic               w_load;
    logic               w_blink_off_nxt;
    logic [SEG_W-1:0]   w_seg_in [NUM_DIG];
    logic [SEG_W-1:0]   r_snap_seg [NUM_DIG];
    logic [NUM_DIG-1:0] r_snap_dp;
    logic [SEG_W-1:0]   w_seg_sel;
    logic               w_dp_sel;
    logic [NUM_DIG-1:0] w_an_nxt;
    logic               w_fd_nxt;
    logic [SEG_W-1:0]   r_seg;
    logic               r_dp;
    logic [NUM_DIG-1:0] r_an;
    logic               r_fd;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .cnt     (w_cnt),
        .cnt_nxt (w_cnt_nxt),
        .tick    (w_tick)
    );

    assign w_seg_in[0] = seg_in0;
    assign w_seg_in[1] = seg_in1;
    assign w_seg_in[2] = seg_in2;
    assign w_seg_in[3] = seg_in3;
    assign w_seg_in[4] = seg_in4;
    assign w_seg_in[5] = seg_in5;

    assign w_wrap = w_tick && (r_idx == dig_idx_t'(NUM_DIG - 1));
    assign w_load = w_wrap || r_load_pend;

`ifdef ALARM_BLINK_EN
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FC_W-1:0] r_fc;
    logic [FC_W-1:0] w_fc_nxt;
    logic            r_phase;
    logic            w_phase_nxt;

    // Frame counter runs whether or not the alarm is active.
    always_comb begin
        w_fc_nxt    = r_fc;
        w_phase_nxt = r_phase;
        if (w_wrap) begin
            if (r_fc == FC_W'(BLINK_FRAMES - 1)) begin
                w_fc_nxt    = '0;
                w_phase_nxt = ~r_phase;
            end else begin
                w_fc_nxt = r_fc + FC_W'(1);
            end
        end
    end

    assign w_blink_off_nxt = alarm && w_phase_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fc    <= '0;
            r_phase <= 1'b0;
        end else begin
            r_fc    <= w_fc_nxt;
            r_phase <= w_phase_nxt;
        end
    end
`else
    localparam int c_unused_blink_frames = BLINK_FRAMES;
    logic          w_unused_alarm;

    assign w_unused_alarm  = alarm;
    assign w_blink_off_nxt = 1'b0;
`endif

    always_comb begin
        w_idx_nxt = r_idx;
        if (w_tick) begin
            w_idx_nxt = (r_idx == dig_idx_t'(NUM_DIG - 1)) ? dig_idx_t'(0)
                                                           : r_idx + dig_idx_t'(1);
        end
    end

    // A slot about to be loaded shows the fresh inputs, not the stale snapshot.
    always_comb begin
        w_seg_sel = '0;
        w_dp_sel  = 1'b0;
        for (int k = 0; k < NUM_DIG; k++) begin
            if (w_idx_nxt == dig_idx_t'(k)) begin
                w_seg_sel = w_load ? w_seg_in[k] : r_snap_seg[k];
                w_dp_sel  = w_load ? dp_mask[k]  : r_snap_dp[k];
            end
        end
    end

    // blank feeds the registered anodes directly, so they go dark one cycle after it rises.
    always_comb begin
        w_an_nxt = AN_OFF;
        if ((w_cnt_nxt >= CNT_W'(DEAD)) && !blank && !w_blink_off_nxt) begin
            w_an_nxt = onehot_low(w_idx_nxt);
        end
    end

    assign w_fd_nxt = (w_idx_nxt == dig_idx_t'(NUM_DIG - 1)) &&
                      (w_cnt_nxt == CNT_W'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idx       <= '0;
            r_load_pend <= 1'b1;
            r_snap_dp   <= '0;
            for (int k = 0; k < NUM_DIG; k++) begin
                r_snap_seg[k] <= '0;
            end
            r_seg <= '0;
            r_dp  <= 1'b0;
            r_an  <= AN_OFF;
            r_fd  <= 1'b0;
        end else begin
            r_idx       <= w_idx_nxt;
            r_load_pend <= 1'b0;
            if (w_load) begin
                r_snap_dp <= dp_mask;
                for (int k = 0; k < NUM_DIG; k++) begin
                    r_snap_seg[k] <= w_seg_in[k];
                end
            end
            r_seg <= w_seg_sel;
            r_dp  <= w_dp_sel;
            r_an  <= w_an_nxt;
            r_fd  <= w_fd_nxt;
        end
    end

    assign seg_out    = r_seg;
    assign dp_out     = r_dp;
    assign an_out     = r_an;
    assign digit_idx  = r_idx;
    assign frame_done = r_fd;

endmodule

`default_nettype wire
